hwpe_stream_tcdm_fetcher: RTL and testbench
===========================================

# hwpe_stream_tcdm_fetcher

Load-side TCDM master that sits directly downstream of the HWPE address generator. It consumes the generated word address and byte strobe, and issues TCDM read requests with req/gnt handshake. It advances the address generator only on granted requests, then packs the responses into a valid/ready HWPE stream. Outstanding requests are bounded by a credit counter, so the internal response FIFO can never overflow.

## Interface
- DATA_WIDTH, 32: TCDM and stream data width in bits.
- STRB_WIDTH, DATA_WIDTH/8: byte-strobe width.
- MAX_OUTSTANDING, 4: credit limit and response FIFO depth; must be at least 2.
- TRANS_CNT, 16: width of the transaction counters.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_mode_i  in  1  test mode; no functional effect.
- clear_i  in  1  synchronous clear of all state.
- start_i  in  1  start a job; sampled only in IDLE.
- trans_size_i  in  TRANS_CNT  number of words in the job; sampled on start.
- addr_i  in  32  word address from the address generator; bits [1:0] are zero.
- strb_i  in  STRB_WIDTH  byte strobe from the address generator.
- addr_enable_o  out  1  enable to the address generator.
- tcdm_req_o  out  1  TCDM request.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_add_o  out  32  TCDM address.
- tcdm_wen_o  out  1  write enable, active-low; held at 1 (read).
- tcdm_be_o  out  STRB_WIDTH  byte enable; held at all-ones.
- tcdm_r_valid_i  in  1  response valid; fixed latency of exactly 1 cycle after grant.
- tcdm_r_data_i  in  DATA_WIDTH  response data.
- stream_valid_o  out  1  output stream valid.
- stream_ready_i  in  1  output stream ready.
- stream_data_o  out  DATA_WIDTH  output stream data.
- stream_strb_o  out  STRB_WIDTH  output stream strobe.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on start_i when trans_size_i != 0. Latch trans_size_i; zero issued_cnt and popped_cnt.
- IDLE to DONE: on start_i when trans_size_i == 0.
- RUN to DONE: when popped_cnt reaches the latched size (the cycle after the last pop).
- DONE to IDLE: unconditionally after one cycle. done_o = (state == DONE).
- Request rule: tcdm_req_o = (state == RUN) and (issued_cnt < size) and (pending < MAX_OUTSTANDING).
- Request stability: once tcdm_req_o is high it stays high until granted.
- Address path: tcdm_add_o = addr_i, combinational.
- addr_enable_o = tcdm_req_o & tcdm_gnt_i. The address generator advances only on a handshake, so the address is stable while waiting for grant.
- On grant: issued_cnt+1, pending+1, and strb_i is captured into strb_q.
- On tcdm_r_valid_i in RUN: write {tcdm_r_data_i, strb_q} into the FIFO.
- tcdm_r_valid_i in IDLE or DONE is ignored; this covers stale responses after a clear.
- Pop on stream_valid_o & stream_ready_i: pending-1, popped_cnt+1.
- Grant and pop in the same cycle: pending unchanged.
- Invariant: pending is at most MAX_OUTSTANDING, and FIFO occupancy is at most pending. The FIFO is never written while full.
- Stream outputs: stream_valid_o = FIFO not empty. Data and strobe come from the FIFO head and are held stable while valid is high and ready is low.
- Counter arithmetic: all counters are unsigned TRANS_CNT bits with no wrap. Maximum job size is 2^TRANS_CNT - 1.
- clear_i has priority over all other events. Any state goes to IDLE; pending, counters and FIFO are zeroed.

## Timing
- Reset values: tcdm_req_o=0, addr_enable_o=0, stream_valid_o=0, done_o=0, busy_o=0, tcdm_wen_o=1, tcdm_be_o=all-ones. stream_data_o and stream_strb_o are 0 while the FIFO is empty after reset.
- start_i at cycle t: state is RUN at t+1; the first request can be issued at t+1.
- Latency: grant at t, r_valid at t+1, stream_valid_o at t+2.
- Throughput: full rate of one word per cycle with MAX_OUTSTANDING >= 3 and ready held high. MAX_OUTSTANDING=2 limits the rate to 2 words per 3 cycles.
- Completion: last pop at t, done_o at t+1, IDLE at t+2.
- Back-to-back jobs: start_i may be asserted in the cycle after DONE.

## Test plan
- Basic job: size=8, gnt tied to 1, ready=1, addresses 0x100..0x11C. Expect 8 requests in 8 consecutive cycles and stream words in issue order. done_o pulses exactly once, 10 cycles after the first request.
- Grant stalls: gnt low for 3 cycles on word 2. Expect tcdm_add_o=0x108 held and addr_enable_o=0 during the stall. No duplicated or skipped words.
- Backpressure: ready=0 for 20 cycles, MAX_OUTSTANDING=4. Expect exactly 4 grants, then req=0 and FIFO full. After ready rises, all 16 words arrive in order.
- Strobe tracking: strb_i=4'b1100 on the first word and 4'b0011 on the last. Expect matching stream_strb_o on those words and 4'b1111 on the others.
- Zero size: start with trans_size_i=0. Expect no request, done_o the next cycle, then IDLE.
- Mid-job clear: clear_i at cycle 5 with 2 words pending. Expect all outputs at reset values next cycle and the stale r_valid ignored. A new size=3 job then completes correctly.

Source files
------------

// File: rtl/hwpe_stream_tcdm_fetcher.sv
// Load-side TCDM master: issues credit-limited read requests from generated
// addresses and returns the responses as a valid/ready stream.
module hwpe_stream_tcdm_fetcher #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TRANS_CNT       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [TRANS_CNT-1:0]  trans_size_i,
    input  logic [31:0]           addr_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    output logic                  addr_enable_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [31:0]           tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [STRB_WIDTH-1:0] tcdm_be_o,
    input  logic                  tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
    output logic                  stream_valid_o,
    input  logic                  stream_ready_i,
    output logic [DATA_WIDTH-1:0] stream_data_o,
    output logic [STRB_WIDTH-1:0] stream_strb_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned PEND_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                state_q, state_d;
    logic [TRANS_CNT-1:0]  size_q, size_d;
    logic [TRANS_CNT-1:0]  issued_q, issued_d;
    logic [TRANS_CNT-1:0]  popped_q, popped_d;
    logic [PEND_W-1:0]     pending_q, pending_d;
    logic [PEND_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0] data_mem_q [MAX_OUTSTANDING];
    logic [STRB_WIDTH-1:0] strb_mem_q [MAX_OUTSTANDING];

    logic req, gnt_hs, pop, fifo_wr;
    logic unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Request depends only on registered state, so it cannot drop before grant.
    assign req     = (state_q == RUN) && (issued_q < size_q)
                     && (pending_q < PEND_W'(MAX_OUTSTANDING));
    assign gnt_hs  = req & tcdm_gnt_i;
    assign fifo_wr = tcdm_r_valid_i && (state_q == RUN);

    assign tcdm_req_o     = req;
    assign addr_enable_o  = gnt_hs;
    assign tcdm_add_o     = addr_i;
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_be_o      = '1;
    assign stream_valid_o = (fifo_cnt_q != '0);
    assign pop            = stream_valid_o & stream_ready_i;
    assign stream_data_o  = data_mem_q[rd_ptr_q];
    assign stream_strb_o  = strb_mem_q[rd_ptr_q];
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        pending_d  = pending_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        strb_d     = strb_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    size_d   = trans_size_i;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (trans_size_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (gnt_hs) begin
                    issued_d = issued_q + TRANS_CNT'(1);
                    strb_d   = strb_i;
                end
                // Leave RUN on the pop that completes the job so done_o follows it directly.
                if (pop) begin
                    popped_d = popped_q + TRANS_CNT'(1);
                    if (popped_d == size_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case ({gnt_hs, pop})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase

        if (fifo_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({fifo_wr, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + PEND_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - PEND_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            size_d     = '0;
            issued_d   = '0;
            popped_d   = '0;
            pending_d  = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            strb_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            size_q     <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            pending_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            strb_q     <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                data_mem_q[i] <= '0;
                strb_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            pending_q  <= pending_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            strb_q     <= strb_d;
            if (clear_i) begin
                for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                    data_mem_q[i] <= '0;
                    strb_mem_q[i] <= '0;
                end
            end else if (fifo_wr) begin
                data_mem_q[wr_ptr_q] <= tcdm_r_data_i;
                strb_mem_q[wr_ptr_q] <= strb_q;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetcher.sv
// Directed bench for hwpe_stream_tcdm_fetcher: a job table plus hand-written
// sequences for zero size and mid-job clear, against a 1-cycle TCDM model.
module tb_hwpe_stream_tcdm_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        test_mode_i;
    logic        clear_i;
    logic        start_i;
    logic [15:0] trans_size_i;
    logic [31:0] addr_i;
    logic [3:0]  strb_i;
    logic        addr_enable_o;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_r_valid_i;
    logic [31:0] tcdm_r_data_i;
    logic        stream_valid_o;
    logic        stream_ready_i;
    logic [31:0] stream_data_o;
    logic [3:0]  stream_strb_o;
    logic        busy_o;
    logic        done_o;

    hwpe_stream_tcdm_fetcher #(
        .DATA_WIDTH      (32),
        .STRB_WIDTH      (4),
        .MAX_OUTSTANDING (4),
        .TRANS_CNT       (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_mode_i    (test_mode_i),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .trans_size_i   (trans_size_i),
        .addr_i         (addr_i),
        .strb_i         (strb_i),
        .addr_enable_o  (addr_enable_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .tcdm_r_data_i  (tcdm_r_data_i),
        .stream_valid_o (stream_valid_o),
        .stream_ready_i (stream_ready_i),
        .stream_data_o  (stream_data_o),
        .stream_strb_o  (stream_strb_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int         size;
        logic [31:0] base;
        int         stall_word;
        int         stall_len;
        int         rdy_off;
        logic [3:0] sf;
        logic [3:0] sl;
        int         exp_cyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Address generator / TCDM model state
    logic [31:0] base;
    int          idx;
    int          cur_size;
    logic [3:0]  cur_sf, cur_sl;
    int          grants;
    logic        s_pop, s_done;
    logic [31:0] s_data;
    logic [3:0]  s_strb;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [3:0] exp_strb(input int i);
        if (i == 0) return cur_sf;
        if (i == cur_size - 1) return cur_sl;
        return 4'hF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_ag();
        addr_i = base + 32'(idx * 4);
        strb_i = exp_strb(idx);
    endtask

    // Samples at the falling edge, then steps past the rising edge and updates the models.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #3;
        hs     = tcdm_req_o & tcdm_gnt_i;
        a      = tcdm_add_o;
        s_pop  = stream_valid_o & stream_ready_i;
        s_data = stream_data_o;
        s_strb = stream_strb_o;
        s_done = done_o;
        @(posedge clk_i);
        #1;
        tcdm_r_valid_i = hs;
        tcdm_r_data_i  = hs ? dfun(a) : '0;
        if (hs) begin
            grants++;
            idx++;
            drive_ag();
        end
    endtask

    task automatic run_job(input vec_t v, input string nm);
        int cyc, popped, done_cyc, stalled;
        base = v.base; idx = 0; cur_size = v.size; cur_sf = v.sf; cur_sl = v.sl;
        grants = 0; drive_ag();
        trans_size_i = 16'(v.size);
        start_i = 1'b1; tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
        #1;
        tick();
        start_i = 1'b0;
        cyc = 0; popped = 0; done_cyc = -1; stalled = 0;
        while (done_cyc < 0 && cyc < 300) begin
            cyc++;
            stream_ready_i = !(v.rdy_off > 0 && cyc <= v.rdy_off);
            tcdm_gnt_i = !(idx == v.stall_word && stalled < v.stall_len);
            #1;
            if (!tcdm_gnt_i && tcdm_req_o) begin
                chk({nm, " stall_addr"}, tcdm_add_o, v.base + 32'(v.stall_word * 4));
                chk({nm, " stall_aen"}, 32'(addr_enable_o), 32'd0);
                stalled++;
            end
            if (v.rdy_off > 0 && cyc == v.rdy_off) begin
                chk({nm, " bp_grants"}, 32'(grants), 32'd4);
                chk({nm, " bp_req"}, 32'(tcdm_req_o), 32'd0);
                chk({nm, " bp_valid"}, 32'(stream_valid_o), 32'd1);
            end
            tick();
            if (s_pop) begin
                chk({nm, " data"}, s_data, dfun(v.base + 32'(popped * 4)));
                chk({nm, " strb"}, 32'(s_strb), 32'(exp_strb(popped)));
                popped++;
            end
            if (s_done) done_cyc = cyc;
        end
        chk({nm, " done_cycle"}, 32'(done_cyc), 32'(v.exp_cyc));
        chk({nm, " words"}, 32'(popped), 32'(v.size));
        chk({nm, " stall_cycles"}, 32'(stalled), 32'(v.stall_len));
        chk({nm, " done_drop"}, 32'(done_o), 32'd0);
        chk({nm, " idle"}, 32'(busy_o), 32'd0);
    endtask

    vec_t vecs [4];

    initial begin
        // size, base, stall_word, stall_len, rdy_off, sf, sl, expected done cycle
        vecs[0] = '{8,  32'h100, -1, 0, 0,  4'hF,    4'hF,    11};
        vecs[1] = '{8,  32'h100,  2, 3, 0,  4'hF,    4'hF,    14};
        vecs[2] = '{16, 32'h400, -1, 0, 20, 4'hF,    4'hF,    37};
        vecs[3] = '{4,  32'h300, -1, 0, 0,  4'b1100, 4'b0011, 7};

        rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        trans_size_i = '0; addr_i = '0; strb_i = 4'hF; tcdm_gnt_i = 1'b1;
        tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; stream_ready_i = 1'b1;
        base = '0; idx = 0; cur_size = 0; cur_sf = 4'hF; cur_sl = 4'hF; grants = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("rst_req", 32'(tcdm_req_o), 32'd0);
        chk("rst_aen", 32'(addr_enable_o), 32'd0);
        chk("rst_valid", 32'(stream_valid_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wen", 32'(tcdm_wen_o), 32'd1);
        chk("rst_be", 32'(tcdm_be_o), 32'hF);
        chk("rst_data", stream_data_o, 32'd0);
        chk("rst_strb", 32'(stream_strb_o), 32'd0);

        // Zero-size job: DONE immediately, no request
        trans_size_i = '0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("zero_done", 32'(done_o), 32'd1);
        chk("zero_busy", 32'(busy_o), 32'd1);
        chk("zero_req", 32'(tcdm_req_o), 32'd0);
        tick();
        chk("zero_done_drop", 32'(done_o), 32'd0);
        chk("zero_idle", 32'(busy_o), 32'd0);

        for (int i = 0; i < 4; i++) run_job(vecs[i], $sformatf("job%0d", i));

        // Mid-job clear with two words outstanding, then a stale response in IDLE
        base = 32'h200; idx = 0; cur_size = 8; cur_sf = 4'hF; cur_sl = 4'hF; drive_ag();
        trans_size_i = 16'd8; start_i = 1'b1; stream_ready_i = 1'b0; tcdm_gnt_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_stale_rvalid", 32'(tcdm_r_valid_i), 32'd1);
        chk("clr_req", 32'(tcdm_req_o), 32'd0);
        chk("clr_aen", 32'(addr_enable_o), 32'd0);
        chk("clr_valid", 32'(stream_valid_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_done", 32'(done_o), 32'd0);
        chk("clr_data", stream_data_o, 32'd0);
        stream_ready_i = 1'b1;
        tick();
        chk("clr_stale_ignored", 32'(stream_valid_o), 32'd0);
        run_job('{3, 32'h500, -1, 0, 0, 4'hF, 4'hF, 6}, "after_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
